// File: rtl/ctrl_pkg.sv
// Shared opcode constants, encodings and per-stage control bundles for the
// in-order pipeline control unit.
package ctrl_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'd19;
   localparam logic [6:0] OPC_OP     = 7'd51;
   localparam logic [6:0] OPC_LOAD   = 7'd3;
   localparam logic [6:0] OPC_STORE  = 7'd35;
   localparam logic [6:0] OPC_JAL    = 7'd111;
   localparam logic [6:0] OPC_JALR   = 7'd103;
   localparam logic [6:0] OPC_LUI    = 7'd55;
   localparam logic [6:0] OPC_AUIPC  = 7'd23;
   localparam logic [6:0] OPC_BRANCH = 7'd99;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_BR   = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   // Write-back source select
   typedef enum logic [2:0] {
      DSEL_PC4    = 3'b000,
      DSEL_ALU    = 3'b001,
      DSEL_PC_IMM = 3'b010,
      DSEL_MEM    = 3'b011,
      DSEL_IMM    = 3'b111
   } dsel_e;

   typedef struct packed {
      logic       aluSrc;
      logic [1:0] aluop;
      logic       branch;
      logic       jump;
   } ex_ctrl_t;

   typedef struct packed {
      logic memRead;
      logic memWrite;
   } mem_ctrl_t;

   typedef struct packed {
      logic  regWrite;
      dsel_e dsel;
   } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode into EX/MEM/WB control bundles plus source
// operand usage; undecodable or invalid instructions produce an all-zero bubble.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic      valid,
   input  logic [6:0] opcode,
   output ex_ctrl_t  ex_ctrl,
   output mem_ctrl_t mem_ctrl,
   output wb_ctrl_t  wb_ctrl,
   output logic      use_rs1,
   output logic      use_rs2,
   output logic      illegal
);

   logic known;

   always_comb begin
      ex_ctrl  = '0;
      mem_ctrl = '0;
      wb_ctrl  = '0;
      use_rs1  = 1'b0;
      use_rs2  = 1'b0;
      known    = 1'b1;
      case (opcode)
         OPC_OP_IMM: begin
            ex_ctrl.aluSrc   = 1'b1;
            ex_ctrl.aluop    = ALUOP_FUNC;
            wb_ctrl.regWrite = 1'b1;
            wb_ctrl.dsel     = DSEL_ALU;
            use_rs1          = 1'b1;
         end
         OPC_OP: begin
            ex_ctrl.aluop    = ALUOP_FUNC;
            wb_ctrl.regWrite = 1'b1;
            wb_ctrl.dsel     = DSEL_ALU;
            use_rs1          = 1'b1;
            use_rs2          = 1'b1;
         end
         OPC_LOAD: begin
            ex_ctrl.aluSrc   = 1'b1;
            ex_ctrl.aluop    = ALUOP_ADD;
            mem_ctrl.memRead = 1'b1;
            wb_ctrl.regWrite = 1'b1;
            wb_ctrl.dsel     = DSEL_MEM;
            use_rs1          = 1'b1;
         end
         OPC_STORE: begin
            ex_ctrl.aluSrc    = 1'b1;
            ex_ctrl.aluop     = ALUOP_ADD;
            mem_ctrl.memWrite = 1'b1;
            wb_ctrl.dsel      = DSEL_ALU;
            use_rs1           = 1'b1;
            use_rs2           = 1'b1;
         end
         OPC_JAL: begin
            ex_ctrl.aluSrc   = 1'b1;
            ex_ctrl.jump     = 1'b1;
            wb_ctrl.regWrite = 1'b1;
            wb_ctrl.dsel     = DSEL_PC4;
         end
         OPC_JALR: begin
            ex_ctrl.aluSrc   = 1'b1;
            ex_ctrl.jump     = 1'b1;
            wb_ctrl.regWrite = 1'b1;
            wb_ctrl.dsel     = DSEL_PC4;
            use_rs1          = 1'b1;
         end
         OPC_LUI: begin
            ex_ctrl.aluSrc   = 1'b1;
            wb_ctrl.regWrite = 1'b1;
            wb_ctrl.dsel     = DSEL_IMM;
         end
         OPC_AUIPC: begin
            wb_ctrl.regWrite = 1'b1;
            wb_ctrl.dsel     = DSEL_PC_IMM;
         end
         OPC_BRANCH: begin
            ex_ctrl.aluop  = ALUOP_BR;
            ex_ctrl.branch = 1'b1;
            use_rs1        = 1'b1;
            use_rs2        = 1'b1;
         end
         default: known = 1'b0;
      endcase

      // Anything that is not a real, decodable instruction becomes a bubble
      if (!(valid && known)) begin
         ex_ctrl  = '0;
         mem_ctrl = '0;
         wb_ctrl  = '0;
         use_rs1  = 1'b0;
         use_rs2  = 1'b0;
      end
      illegal = valid & ~known;
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: ID->EX->MEM->WB control registers, load-use hold,
// branch flush and EX operand forwarding selects.
module pipe_ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int DSEL_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [6:0]        id_opcode,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              ex_branch_taken,
   input  logic              stall_ext,
   output logic              hold_id,
   output logic              flush_id,
   output logic              illegal_instr,
   output logic              ex_valid,
   output logic              ex_aluSrc,
   output logic              ex_branch,
   output logic              ex_jump,
   output logic [1:0]        ex_aluop,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic              mem_valid,
   output logic              mem_memRead,
   output logic              mem_memWrite,
   output logic [REG_AW-1:0] mem_rd,
   output logic              wb_valid,
   output logic              wb_regWrite,
   output logic [DSEL_W-1:0] wb_dsel,
   output logic [REG_AW-1:0] wb_rd,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);

   ex_ctrl_t  dec_ex;
   mem_ctrl_t dec_mem;
   wb_ctrl_t  dec_wb;
   logic      dec_use_rs1;
   logic      dec_use_rs2;
   logic      dec_illegal;

   ctrl_decode u_decode (
      .valid    (id_valid),
      .opcode   (id_opcode),
      .ex_ctrl  (dec_ex),
      .mem_ctrl (dec_mem),
      .wb_ctrl  (dec_wb),
      .use_rs1  (dec_use_rs1),
      .use_rs2  (dec_use_rs2),
      .illegal  (dec_illegal)
   );

   logic              ex_valid_reg,  ex_valid_next;
   ex_ctrl_t          ex_ex_reg,     ex_ex_next;
   mem_ctrl_t         ex_mem_reg,    ex_mem_next;
   wb_ctrl_t          ex_wb_reg,     ex_wb_next;
   logic [REG_AW-1:0] ex_rs1_reg,    ex_rs1_next;
   logic [REG_AW-1:0] ex_rs2_reg,    ex_rs2_next;
   logic [REG_AW-1:0] ex_rd_reg,     ex_rd_next;
   logic              mem_valid_reg;
   mem_ctrl_t         mem_mem_reg;
   wb_ctrl_t          mem_wb_reg;
   logic [REG_AW-1:0] mem_rd_reg;
   logic              wb_valid_reg;
   wb_ctrl_t          wb_wb_reg;
   logic [REG_AW-1:0] wb_rd_reg;

   logic load_use;
   logic bubble;

   // Load-use: the instruction in ID needs a value the load in EX has not fetched yet
   always_comb begin
      load_use = ex_valid_reg && ex_mem_reg.memRead && (ex_rd_reg != '0) && id_valid &&
                 ((dec_use_rs1 && (id_rs1 == ex_rd_reg)) ||
                  (dec_use_rs2 && (id_rs2 == ex_rd_reg)));
   end

   assign flush_id      = ex_branch_taken;
   assign hold_id       = rst_n & load_use & ~ex_branch_taken;
   assign illegal_instr = dec_illegal;
   assign bubble        = hold_id | flush_id | ~id_valid | dec_illegal;

   always_comb begin
      ex_valid_next = 1'b0;
      ex_ex_next    = '0;
      ex_mem_next   = '0;
      ex_wb_next    = '0;
      ex_rs1_next   = '0;
      ex_rs2_next   = '0;
      ex_rd_next    = '0;
      if (!bubble) begin
         ex_valid_next = 1'b1;
         ex_ex_next    = dec_ex;
         ex_mem_next   = dec_mem;
         ex_wb_next    = dec_wb;
         ex_rs1_next   = id_rs1;
         ex_rs2_next   = id_rs2;
         ex_rd_next    = id_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid_reg  <= 1'b0;
         ex_ex_reg     <= '0;
         ex_mem_reg    <= '0;
         ex_wb_reg     <= '0;
         ex_rs1_reg    <= '0;
         ex_rs2_reg    <= '0;
         ex_rd_reg     <= '0;
         mem_valid_reg <= 1'b0;
         mem_mem_reg   <= '0;
         mem_wb_reg    <= '0;
         mem_rd_reg    <= '0;
         wb_valid_reg  <= 1'b0;
         wb_wb_reg     <= '0;
         wb_rd_reg     <= '0;
      end else if (!stall_ext) begin
         ex_valid_reg  <= ex_valid_next;
         ex_ex_reg     <= ex_ex_next;
         ex_mem_reg    <= ex_mem_next;
         ex_wb_reg     <= ex_wb_next;
         ex_rs1_reg    <= ex_rs1_next;
         ex_rs2_reg    <= ex_rs2_next;
         ex_rd_reg     <= ex_rd_next;
         mem_valid_reg <= ex_valid_reg;
         mem_mem_reg   <= ex_mem_reg;
         mem_wb_reg    <= ex_wb_reg;
         mem_rd_reg    <= ex_rd_reg;
         wb_valid_reg  <= mem_valid_reg;
         wb_wb_reg     <= mem_wb_reg;
         wb_rd_reg     <= mem_rd_reg;
      end
   end

   // One forwarding comparator pair per EX source operand; MEM outranks WB
   logic [REG_AW-1:0] ex_src [2];
   logic [1:0]        fwd_sel [2];
   assign ex_src[0] = ex_rs1_reg;
   assign ex_src[1] = ex_rs2_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         logic mem_hit;
         logic wb_hit;
         assign mem_hit = mem_valid_reg && mem_wb_reg.regWrite && (mem_rd_reg != '0) &&
                          (mem_rd_reg == ex_src[gi]);
         assign wb_hit  = wb_valid_reg && wb_wb_reg.regWrite && (wb_rd_reg != '0) &&
                          (wb_rd_reg == ex_src[gi]);
         assign fwd_sel[gi] = !rst_n  ? 2'b00 :
                              mem_hit ? 2'b10 :
                              wb_hit  ? 2'b01 : 2'b00;
      end
   endgenerate

   assign fwd_a = fwd_sel[0];
   assign fwd_b = fwd_sel[1];

   assign ex_valid     = ex_valid_reg;
   assign ex_aluSrc    = ex_ex_reg.aluSrc;
   assign ex_aluop     = ex_ex_reg.aluop;
   assign ex_branch    = ex_ex_reg.branch;
   assign ex_jump      = ex_ex_reg.jump;
   assign ex_rs1       = ex_rs1_reg;
   assign ex_rs2       = ex_rs2_reg;
   assign ex_rd        = ex_rd_reg;
   assign mem_valid    = mem_valid_reg;
   assign mem_memRead  = mem_mem_reg.memRead;
   assign mem_memWrite = mem_mem_reg.memWrite;
   assign mem_rd       = mem_rd_reg;
   assign wb_valid     = wb_valid_reg;
   assign wb_regWrite  = wb_wb_reg.regWrite;
   assign wb_dsel      = DSEL_W'(wb_wb_reg.dsel);
   assign wb_rd        = wb_rd_reg;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit with a write-back scoreboard: expected
// retirements are queued when issued and checked when wb_valid appears.
module tb_pipe_ctrl_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid;
   logic [6:0] id_opcode;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       ex_branch_taken;
   logic       stall_ext;
   logic       hold_id, flush_id, illegal_instr;
   logic       ex_valid, ex_aluSrc, ex_branch, ex_jump;
   logic [1:0] ex_aluop;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic       mem_valid, mem_memRead, mem_memWrite;
   logic [4:0] mem_rd;
   logic       wb_valid, wb_regWrite;
   logic [2:0] wb_dsel;
   logic [4:0] wb_rd;
   logic [1:0] fwd_a, fwd_b;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       rw;
      logic [2:0] dsel;
      logic [4:0] rd;
   } wb_exp_t;
   wb_exp_t sbq[$];

   typedef struct packed {
      logic [6:0] op;
      logic       as;
      logic [1:0] ao;
      logic       br, jp, mr, mw, rw;
      logic [2:0] ds;
   } dec_t;
   dec_t tbl [9];

   always #5 clk = ~clk;

   pipe_ctrl_unit #(.REG_AW(5), .DSEL_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext),
      .hold_id(hold_id), .flush_id(flush_id), .illegal_instr(illegal_instr),
      .ex_valid(ex_valid), .ex_aluSrc(ex_aluSrc), .ex_branch(ex_branch),
      .ex_jump(ex_jump), .ex_aluop(ex_aluop), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_memRead(mem_memRead),
      .mem_memWrite(mem_memWrite), .mem_rd(mem_rd), .wb_valid(wb_valid),
      .wb_regWrite(wb_regWrite), .wb_dsel(wb_dsel), .wb_rd(wb_rd),
      .fwd_a(fwd_a), .fwd_b(fwd_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [6:0] op,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
      id_valid  = v;
      id_opcode = op;
      id_rs1    = r1;
      id_rs2    = r2;
      id_rd     = rd;
   endtask

   task automatic push(input logic rw, input logic [2:0] ds, input logic [4:0] rd);
      wb_exp_t e;
      e.rw = rw; e.dsel = ds; e.rd = rd;
      sbq.push_back(e);
   endtask

   // Advance one clock and retire anything that reached WB
   task automatic step();
      wb_exp_t e;
      @(posedge clk);
      #1;
      if (wb_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("wb_unexpected_retire", 32'(sbq.size()), 32'd1);
         end else begin
            e = sbq.pop_front();
            chk("wb_regWrite", {31'b0, wb_regWrite}, {31'b0, e.rw});
            chk("wb_dsel", {29'b0, wb_dsel}, {29'b0, e.dsel});
            chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
         end
      end else begin
         chk("wb_valid_known", {31'b0, wb_valid}, 32'd0);
         chk("wb_idle_regWrite", {31'b0, wb_regWrite}, 32'd0);
      end
   endtask

   task automatic idle(input int n);
      drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      tbl[0] = '{op:7'd19,  as:1, ao:2'b10, br:0, jp:0, mr:0, mw:0, rw:1, ds:3'b001};
      tbl[1] = '{op:7'd51,  as:0, ao:2'b10, br:0, jp:0, mr:0, mw:0, rw:1, ds:3'b001};
      tbl[2] = '{op:7'd3,   as:1, ao:2'b00, br:0, jp:0, mr:1, mw:0, rw:1, ds:3'b011};
      tbl[3] = '{op:7'd35,  as:1, ao:2'b00, br:0, jp:0, mr:0, mw:1, rw:0, ds:3'b001};
      tbl[4] = '{op:7'd111, as:1, ao:2'b00, br:0, jp:1, mr:0, mw:0, rw:1, ds:3'b000};
      tbl[5] = '{op:7'd103, as:1, ao:2'b00, br:0, jp:1, mr:0, mw:0, rw:1, ds:3'b000};
      tbl[6] = '{op:7'd55,  as:1, ao:2'b00, br:0, jp:0, mr:0, mw:0, rw:1, ds:3'b111};
      tbl[7] = '{op:7'd23,  as:0, ao:2'b00, br:0, jp:0, mr:0, mw:0, rw:1, ds:3'b010};
      tbl[8] = '{op:7'd99,  as:0, ao:2'b01, br:1, jp:0, mr:0, mw:0, rw:0, ds:3'b000};

      // Reset with a live OP sitting in ID
      rst_n = 1'b0; stall_ext = 1'b0; ex_branch_taken = 1'b0;
      drive(1'b1, 7'h7F, 5'd1, 5'd2, 5'd3);
      #1;
      chk("rst_illegal_follows_id", {31'b0, illegal_instr}, 32'd1);
      chk("rst_hold", {31'b0, hold_id}, 32'd0);
      chk("rst_fwd_a", {30'b0, fwd_a}, 32'd0);
      chk("rst_fwd_b", {30'b0, fwd_b}, 32'd0);
      drive(1'b1, 7'd51, 5'd1, 5'd2, 5'd3);
      #1;
      chk("rst_illegal_op", {31'b0, illegal_instr}, 32'd0);
      step();
      step();
      chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
      chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
      chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("rst_ex_rd", {27'b0, ex_rd}, 32'd0);
      rst_n = 1'b1;
      push(1'b1, 3'b001, 5'd3);
      step();
      chk("post_rst_ex_valid", {31'b0, ex_valid}, 32'd1);
      chk("post_rst_ex_rd", {27'b0, ex_rd}, 32'd3);
      drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      step();
      chk("post_rst_mem_valid", {31'b0, mem_valid}, 32'd1);
      step();
      chk("post_rst_wb_regWrite", {31'b0, wb_regWrite}, 32'd1);

      // Load-use: one-cycle hold, EX bubble, then WB forward
      idle(2);
      drive(1'b1, 7'd3, 5'd1, 5'd0, 5'd5);
      push(1'b1, 3'b011, 5'd5);
      step();
      drive(1'b1, 7'd51, 5'd5, 5'd2, 5'd6);
      #1;
      chk("lu_hold_on", {31'b0, hold_id}, 32'd1);
      step();
      chk("lu_ex_bubble", {31'b0, ex_valid}, 32'd0);
      chk("lu_hold_off", {31'b0, hold_id}, 32'd0);
      push(1'b1, 3'b001, 5'd6);
      step();
      chk("lu_ex_rd", {27'b0, ex_rd}, 32'd6);
      chk("lu_fwd_a_wb", {30'b0, fwd_a}, 32'd1);
      chk("lu_fwd_b", {30'b0, fwd_b}, 32'd0);

      // Forwarding: MEM hit, both-hit priority, mixed MEM/WB
      idle(3);
      drive(1'b1, 7'd51, 5'd1, 5'd2, 5'd7);  push(1'b1, 3'b001, 5'd7); step();
      drive(1'b1, 7'd51, 5'd3, 5'd7, 5'd8);  push(1'b1, 3'b001, 5'd8); step();
      chk("fw1_fwd_b_mem", {30'b0, fwd_b}, 32'd2);
      chk("fw1_fwd_a_none", {30'b0, fwd_a}, 32'd0);
      drive(1'b1, 7'd51, 5'd1, 5'd2, 5'd7);  push(1'b1, 3'b001, 5'd7); step();
      chk("fw_no_match_a", {30'b0, fwd_a}, 32'd0);
      drive(1'b1, 7'd51, 5'd1, 5'd2, 5'd7);  push(1'b1, 3'b001, 5'd7); step();
      drive(1'b1, 7'd51, 5'd7, 5'd7, 5'd9);  push(1'b1, 3'b001, 5'd9); step();
      chk("fw2_fwd_a_both", {30'b0, fwd_a}, 32'd2);
      chk("fw2_fwd_b_both", {30'b0, fwd_b}, 32'd2);
      drive(1'b1, 7'd51, 5'd7, 5'd9, 5'd1);  push(1'b1, 3'b001, 5'd1); step();
      chk("fw3_fwd_a_wb", {30'b0, fwd_a}, 32'd1);
      chk("fw3_fwd_b_mem", {30'b0, fwd_b}, 32'd2);

      // Flush overrides a pending load-use hold
      idle(3);
      drive(1'b1, 7'd3, 5'd1, 5'd0, 5'd5);  push(1'b1, 3'b011, 5'd5); step();
      drive(1'b1, 7'd51, 5'd5, 5'd2, 5'd10);
      ex_branch_taken = 1'b1;
      #1;
      chk("fl_hold", {31'b0, hold_id}, 32'd0);
      chk("fl_flush", {31'b0, flush_id}, 32'd1);
      step();
      chk("fl_ex_bubble", {31'b0, ex_valid}, 32'd0);
      ex_branch_taken = 1'b0;
      idle(1);
      chk("fl_flush_off", {31'b0, flush_id}, 32'd0);

      // External stall freezes every stage
      idle(3);
      drive(1'b1, 7'd51, 5'd1, 5'd2, 5'd11); push(1'b1, 3'b001, 5'd11); step();
      drive(1'b1, 7'd51, 5'd1, 5'd2, 5'd12); push(1'b1, 3'b001, 5'd12); step();
      stall_ext = 1'b1;
      drive(1'b1, 7'd51, 5'd12, 5'd2, 5'd13);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st_ex_valid", {31'b0, ex_valid}, 32'd1);
         chk("st_ex_rd", {27'b0, ex_rd}, 32'd12);
         chk("st_mem_rd", {27'b0, mem_rd}, 32'd11);
         chk("st_mem_valid", {31'b0, mem_valid}, 32'd1);
         chk("st_fwd_a", {30'b0, fwd_a}, 32'd0);
      end
      stall_ext = 1'b0;
      idle(3);

      // Loads to x0 never cause a hold or a forward
      drive(1'b1, 7'd3, 5'd1, 5'd0, 5'd0);  push(1'b1, 3'b011, 5'd0); step();
      drive(1'b1, 7'd51, 5'd0, 5'd0, 5'd14);
      #1;
      chk("x0_hold", {31'b0, hold_id}, 32'd0);
      push(1'b1, 3'b001, 5'd14);
      step();
      chk("x0_ex_valid", {31'b0, ex_valid}, 32'd1);
      chk("x0_fwd_a", {30'b0, fwd_a}, 32'd0);

      // Undecodable opcode becomes an EX bubble
      drive(1'b1, 7'h7F, 5'd1, 5'd2, 5'd15);
      #1;
      chk("ill_flag", {31'b0, illegal_instr}, 32'd1);
      step();
      chk("ill_ex_bubble", {31'b0, ex_valid}, 32'd0);
      drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      #1;
      chk("ill_flag_clear", {31'b0, illegal_instr}, 32'd0);
      idle(3);

      // Full decode table through EX, MEM and WB
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, tbl[i].op, 5'd1, 5'd2, 5'(20 + i));
         push(tbl[i].rw, tbl[i].ds, 5'(20 + i));
         step();
         chk("dec_ex_valid", {31'b0, ex_valid}, 32'd1);
         chk("dec_aluSrc", {31'b0, ex_aluSrc}, {31'b0, tbl[i].as});
         chk("dec_aluop", {30'b0, ex_aluop}, {30'b0, tbl[i].ao});
         chk("dec_branch", {31'b0, ex_branch}, {31'b0, tbl[i].br});
         chk("dec_jump", {31'b0, ex_jump}, {31'b0, tbl[i].jp});
         drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
         step();
         chk("dec_memRead", {31'b0, mem_memRead}, {31'b0, tbl[i].mr});
         chk("dec_memWrite", {31'b0, mem_memWrite}, {31'b0, tbl[i].mw});
      end
      idle(4);
      chk("sb_drained", 32'(sbq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter REG_AW, default 5, register-address width (4 selects RV32E).
REQ-002 Parameter DSEL_W, default 3, width of the write-back data select.
REQ-003 One clock; reset is synchronous and active-low; ports named clk and rst_n.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 id_valid  in  1  ID stage holds a real instruction.
REQ-007 id_opcode  in  7  ID-stage opcode field.
REQ-008 id_rs1, id_rs2, id_rd  in  REG_AW each  ID-stage register addresses.
REQ-009 ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle.
REQ-010 stall_ext  in  1  external memory stall; freezes all stage registers.
REQ-011 hold_id  out  1  load-use stall; IF/ID registers must not advance.
REQ-012 flush_id  out  1  equals ex_branch_taken; IF/ID contents discarded.
REQ-013 illegal_instr  out  1  id_valid with an undecodable opcode.
REQ-014 ex_valid, ex_aluSrc, ex_branch, ex_jump  out  1 each; ex_aluop out 2; ex_rs1, ex_rs2, ex_rd out REG_AW.
REQ-015 mem_valid, mem_memRead, mem_memWrite  out  1 each; mem_rd out REG_AW.
REQ-016 wb_valid, wb_regWrite  out  1 each; wb_dsel out DSEL_W; wb_rd out REG_AW.
REQ-017 fwd_a, fwd_b  out  2 each  EX operand forwarding selects.

Function
REQ-018 Decode table: OP-IMM(19) dsel=001 aluSrc=1 regWrite=1 aluop=10; OP(51) dsel=001 aluSrc=0 regWrite=1 aluop=10; LOAD(3) dsel=011 memRead=1 aluSrc=1 regWrite=1 aluop=00.
REQ-019 Decode table: STORE(35) dsel=001 memWrite=1 aluSrc=1 aluop=00; JAL(111)/JALR(103) dsel=000 aluSrc=1 regWrite=1 jump=1 branch=0.
REQ-020 Decode table: LUI(55) dsel=111 aluSrc=1 regWrite=1; AUIPC(23) dsel=010 regWrite=1; BRANCH(99) aluop=01 branch=1; all other fields 0.
REQ-021 Any other opcode with id_valid=1: illegal_instr=1, all decoded controls 0 (bubble).
REQ-022 Operand use: rs1 used by OP-IMM, OP, LOAD, STORE, BRANCH, JALR; rs2 used by OP, STORE, BRANCH.
REQ-023 hold_id=1 when ex_valid & ex_memRead & ex_rd!=0 & ID uses a source equal to ex_rd & id_valid & !ex_branch_taken.
REQ-024 Each rising edge with stall_ext=0: ID->EX, EX->MEM, MEM->WB advance by one stage; latency opcode-to-WB is 3 cycles.
REQ-025 hold_id=1 or flush_id=1: EX loads a bubble (ex_valid=0, all EX/MEM/WB controls 0); MEM and WB still advance.
REQ-026 flush_id has priority over hold_id; a flush cycle never asserts hold_id.
REQ-027 Bubble and invalid stages: controls are forced 0 so no regWrite/memWrite escapes from an invalid stage.
REQ-028 stall_ext=1: all stage registers hold; hold_id/flush_id/fwd still computed combinationally from held state.
REQ-029 fwd_a=10 if mem_valid & mem regWrite & mem_rd!=0 & mem_rd==ex_rs1; else 01 for the same test on WB; else 00; fwd_b same for ex_rs2.
REQ-030 The MEM match outranks the WB match when both hit.
REQ-031 Register x0 (address 0) never triggers hold_id or forwarding.

Reset
REQ-032 rst_n=0 at a rising edge clears every stage valid, control, and rd/rs field to 0; this overrides stall_ext.
REQ-033 With rst_n=0: hold_id=0, fwd_a=fwd_b=00, illegal_instr reflects ID inputs only.

Structure
REQ-034 Package ctrl_pkg holds opcode localparams, the dsel encoding enum, the aluop encodings, and the packed ex/mem/wb control structs.
REQ-035 Sub-module ctrl_decode holds the combinational opcode-to-bundle decode (REQ-018..022); pipe_ctrl_unit holds the stage registers, hazard logic, and forwarding logic.

Verification
REQ-036 Reset: rst_n=0 for 2 cycles with id_valid=1 and opcode=51, then release; all ex/mem/wb valids are 0 until the first post-reset edge; regWrite reaches WB 3 cycles later.
REQ-037 Load-use: LOAD rd=5, next instruction OP rs1=5; hold_id=1 for exactly 1 cycle; EX bubble; then fwd_a=01 when the OP reaches EX.
REQ-038 Forwarding: OP rd=7 followed by OP rs2=7, then OP rd=7 followed by OP rs1=7 and rs2=7; first case fwd_b=10; when both MEM and WB match, fwd=10.
REQ-039 Flush with load-use: ex_branch_taken=1 while ID holds a load-use dependent instruction; hold_id=0, ex_valid=0 next cycle, no regWrite from the flushed instruction.
REQ-040 Stall/x0/illegal: stall_ext=1 for 3 cycles holds all stage outputs unchanged; LOAD rd=0 followed by a use of rs1=0 gives hold_id=0; opcode 0x7F gives illegal_instr=1 and a bubble in EX.
